// File: rtl/pulse_id_monitor.sv
// pulse_id_monitor: sits between the embedded receiver and the board I/O.
// Latches the pulse-ID on each trigger and tracks that consecutive IDs step
// by one. A gap adds to a saturating missed-pulse count. A duplicate, a
// backward step or a gap fires a stretched sequence-error LED. A timeout
// detects trigger loss. A window of the latched ID is shown on DIGITS
// seven-segment digits.
//
// Ports:
//   clk_i, reset_ni       clock, async active-low reset
//   trigger_i, pulse_id_i trigger strobe and the ID valid in that cycle
//   error_i               receiver error strobe (LED only)
//   window_i              nibble index shown on digit 0
//   freeze_i              hold the displayed ID
//   clear_i               sync clear of counters/status (the display is kept)
//   hex_o                 active-low segments, digit k at [7k+6:7k], bit0=a
//   missed_o              saturating missed-pulse count
//   synced_o, timeout_o   TRACK / LOST state flags
//   trig_led_o, err_led_o, seq_err_o  stretched strobes

// Retriggerable pulse stretcher: the output is high from the cycle after
// in_i, until EXTEND_CYCLES cycles after the last high in_i.
module pid_stretch #(
  parameter int EXTEND_CYCLES = 5000000
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o
);
  localparam int EW = $clog2(EXTEND_CYCLES + 1);

  logic [EW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (in_i)          cnt_d = EW'(EXTEND_CYCLES);
    else if (cnt_q != '0)   cnt_d = cnt_q - EW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) cnt_q <= '0;
    else           cnt_q <= cnt_d;

  assign out_o = (cnt_q != '0);
endmodule

// One display digit. It picks nibble (window_i + K) of id_i and registers
// the segment pattern. Indices past the top nibble are shown blank.
module pid_hex_digit #(
  parameter int ID_WIDTH  = 64,
  parameter int WIN_WIDTH = 4,
  parameter int IW        = 8,
  parameter int K         = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [ID_WIDTH-1:0]  id_i,
  input  logic [WIN_WIDTH-1:0] window_i,
  output logic [6:0]           seg_o
);
  localparam int NIB = ID_WIDTH / 4;
  // The reset value assumes window 0: the digit shows "0", or blank if the
  // digit itself lies past the top nibble.
  localparam logic [6:0] RST_SEG = (K < NIB) ? 7'h40 : 7'h7F;

  logic [IW-1:0]       idx;
  logic [ID_WIDTH-1:0] sh;
  logic [3:0]          nib;
  logic                blank;
  logic [6:0]          dec;
  logic [6:0]          seg_q;

  assign idx   = IW'(window_i) + IW'(K);
  assign blank = (idx >= IW'(NIB));
  assign sh    = id_i >> {idx, 2'b00};
  assign nib   = sh[3:0];

  always_comb begin
    dec = 7'h7F;
    unique case (nib)
      4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  4'hF: dec = 7'h0E;
      default: dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) seg_q <= RST_SEG;
    else           seg_q <= blank ? 7'h7F : dec;

  assign seg_o = seg_q;
endmodule

module pulse_id_monitor #(
  parameter int ID_WIDTH       = 64,
  parameter int DIGITS         = 5,
  parameter int WIN_WIDTH      = 4,
  parameter int EXTEND_CYCLES  = 5000000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  trigger_i,
  input  logic [ID_WIDTH-1:0]   pulse_id_i,
  input  logic                  error_i,
  input  logic [WIN_WIDTH-1:0]  window_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  output logic [7*DIGITS-1:0]   hex_o,
  output logic [CNT_WIDTH-1:0]  missed_o,
  output logic                  synced_o,
  output logic                  timeout_o,
  output logic                  trig_led_o,
  output logic                  err_led_o,
  output logic                  seq_err_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = ((ID_WIDTH > CNT_WIDTH) ? ID_WIDTH : CNT_WIDTH) + 1;
  localparam int IW = WIN_WIDTH + $clog2(DIGITS + 1) + 1;
  localparam logic [SW-1:0] SAT = {{(SW-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOST = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;
  logic [ID_WIDTH-1:0] disp_q, disp_d;
  logic [CNT_WIDTH-1:0] missed_q, missed_d;
  logic [TW-1:0]       tmo_q, tmo_d;

  logic                trig_ok, track_trig, tmo_hit, seq_bad, gap, seq_evt;
  logic [ID_WIDTH-1:0] delta;
  logic [SW-1:0]       sum;

  // clear_i overrides a trigger in the same cycle.
  assign trig_ok    = trigger_i & ~clear_i;
  assign track_trig = trig_ok & (state_q == TRACK);
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // Modular step. A zero step or a step in the upper half is a duplicate or
  // a backward step, not a gap.
  assign delta   = pulse_id_i - last_id_q;
  assign seq_bad = (delta == '0) | delta[ID_WIDTH-1];
  assign gap     = ~seq_bad & (delta != ID_WIDTH'(1));
  assign seq_evt = track_trig & (delta != ID_WIDTH'(1));
  // Widened so that a huge gap saturates instead of wrapping.
  assign sum     = SW'(missed_q) + SW'(delta) - SW'(1);

  // FSM: state register
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig_ok) state_d = TRACK;
      TRACK:   if (!trig_ok && tmo_hit) state_d = LOST;
      LOST:    if (trig_ok) state_d = TRACK;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
  end

  // FSM: outputs
  always_comb begin
    synced_o  = (state_q == TRACK);
    timeout_o = (state_q == LOST);
  end

  // Datapath next state
  always_comb begin
    last_id_d = trig_ok ? pulse_id_i : last_id_q;
    disp_d    = (trig_ok && !freeze_i) ? pulse_id_i : disp_q;

    missed_d = missed_q;
    if (clear_i)
      missed_d = '0;
    else if (track_trig && gap)
      missed_d = (sum > SAT) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];

    // The timer only runs in TRACK. It restarts on each trigger.
    if (clear_i || trig_ok || state_q != TRACK) tmo_d = '0;
    else                                        tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      last_id_q <= '0;
      disp_q    <= '0;
      missed_q  <= '0;
      tmo_q     <= '0;
    end else begin
      last_id_q <= last_id_d;
      disp_q    <= disp_d;
      missed_q  <= missed_d;
      tmo_q     <= tmo_d;
    end

  assign missed_o = missed_q;

  // Stretchers: [0] trigger, [1] receiver error, [2] sequence error
  logic [2:0] str_in, str_out;
  assign str_in = {seq_evt, error_i, trigger_i};

  for (genvar i = 0; i < 3; i++) begin : g_str
    pid_stretch #(.EXTEND_CYCLES(EXTEND_CYCLES)) u_str (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .clr_i   (clear_i),
      .in_i    (str_in[i]),
      .out_o   (str_out[i])
    );
  end

  assign trig_led_o = str_out[0];
  assign err_led_o  = str_out[1];
  assign seq_err_o  = str_out[2];

  // Display digits
  logic [DIGITS-1:0][6:0] hex_w;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    pid_hex_digit #(
      .ID_WIDTH (ID_WIDTH),
      .WIN_WIDTH(WIN_WIDTH),
      .IW       (IW),
      .K        (k)
    ) u_dig (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .id_i    (disp_q),
      .window_i(window_i),
      .seg_o   (hex_w[k])
    );
  end

  assign hex_o = hex_w;
endmodule

// File: tb/tb_pulse_id_monitor.sv
module tb_pulse_id_monitor;
  localparam int IDW = 64;
  localparam int DIG = 5;
  localparam int WW  = 4;
  localparam int EXT = 8;
  localparam int TMO = 100;
  localparam int CW  = 4;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S5 = 7'h12;
  localparam logic [6:0] SA = 7'h08, SB = 7'h7F;

  logic            clk, rst_n, trig, err, frz, clr;
  logic [IDW-1:0]  pid;
  logic [WW-1:0]   win;
  logic [7*DIG-1:0] hex;
  logic [CW-1:0]   missed;
  logic            synced, tmo, trig_led, err_led, seq_err;

  int n_chk = 0;
  int n_err = 0;

  pulse_id_monitor #(
    .ID_WIDTH(IDW), .DIGITS(DIG), .WIN_WIDTH(WW),
    .EXTEND_CYCLES(EXT), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .trigger_i(trig), .pulse_id_i(pid),
    .error_i(err), .window_i(win), .freeze_i(frz), .clear_i(clr),
    .hex_o(hex), .missed_o(missed), .synced_o(synced), .timeout_o(tmo),
    .trig_led_o(trig_led), .err_led_o(err_led), .seq_err_o(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge and outputs are sampled there.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [IDW-1:0] id);
    trig = 1'b1; pid = id;
    tick();
    trig = 1'b0;
  endtask

  function automatic logic [63:0] hx(input logic [6:0] d4, d3, d2, d1, d0);
    return 64'({d4, d3, d2, d1, d0});
  endfunction

  initial begin
    rst_n = 1'b0; trig = 1'b0; err = 1'b0; frz = 1'b0; clr = 1'b0;
    pid = '0; win = '0;
    tick(); tick();
    chk("rst_synced", 64'(synced), 64'd0);
    chk("rst_timeout", 64'(tmo), 64'd0);
    chk("rst_missed", 64'(missed), 64'd0);
    chk("rst_leds", 64'({trig_led, err_led, seq_err}), 64'd0);
    chk("rst_hex", 64'(hex), hx(S0, S0, S0, S0, S0));
    rst_n = 1'b1;
    tick();

    // In-order IDs
    pulse(64'h10);
    chk("seq_synced", 64'(synced), 64'd1);
    chk("seq_trigled", 64'(trig_led), 64'd1);
    pulse(64'h11);
    pulse(64'h12);
    chk("seq_hex_lat", 64'(hex), hx(S0, S0, S0, S1, S1));
    chk("seq_missed", 64'(missed), 64'd0);
    chk("seq_noerr", 64'(seq_err), 64'd0);
    tick();
    chk("seq_hex", 64'(hex), hx(S0, S0, S0, S1, S2));

    // Error strobe only lights its LED
    err = 1'b1; tick(); err = 1'b0;
    chk("err_led", 64'(err_led), 64'd1);
    chk("err_state", 64'(synced), 64'd1);

    // Clear, then resync at 0x100 and skip to 0x105
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_synced", 64'(synced), 64'd0);
    chk("clr_leds", 64'({trig_led, err_led}), 64'd0);
    pulse(64'h100);
    chk("resync_missed", 64'(missed), 64'd0);
    pulse(64'h105);
    chk("gap_missed", 64'(missed), 64'd4);
    chk("gap_seqerr", 64'(seq_err), 64'd1);
    repeat (EXT - 1) tick();
    chk("stretch_last", 64'(seq_err), 64'd1);
    tick();
    chk("stretch_end", 64'(seq_err), 64'd0);
    pulse(64'h103);
    chk("back_missed", 64'(missed), 64'd4);
    chk("back_seqerr", 64'(seq_err), 64'd1);
    pulse(64'h103);
    chk("dup_missed", 64'(missed), 64'd4);
    pulse(64'h104);
    pulse(64'h118);
    chk("sat_missed", 64'(missed), 64'd15);

    // Clear wins over a simultaneous trigger
    clr = 1'b1; trig = 1'b1; pid = 64'h119;
    tick();
    clr = 1'b0; trig = 1'b0;
    chk("clrtrig_missed", 64'(missed), 64'd0);
    chk("clrtrig_leds", 64'({trig_led, seq_err}), 64'd0);
    tick();
    chk("clrtrig_idle", 64'(synced), 64'd0);

    // Timeout
    pulse(64'h200);
    pulse(64'h203);
    chk("tmo_pre_missed", 64'(missed), 64'd2);
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", 64'({synced, tmo}), 64'b10);
    tick();
    chk("tmo_lost", 64'({synced, tmo}), 64'b01);
    pulse(64'h500);
    chk("tmo_resync", 64'({synced, tmo}), 64'b10);
    chk("tmo_missed", 64'(missed), 64'd2);
    repeat (TMO - 1) tick();
    pulse(64'h501);
    chk("tmo_trig_wins", 64'({synced, tmo}), 64'b10);
    chk("tmo_trig_missed", 64'(missed), 64'd2);

    // Window
    pulse(64'hA000_0000_0000_0502);
    chk("big_back_missed", 64'(missed), 64'd2);
    win = 4'd15; tick();
    chk("win15", 64'(hex), hx(SB, SB, SB, SB, SA));
    win = 4'd14; tick();
    chk("win14", 64'(hex), hx(SB, SB, SB, SA, S0));
    win = 4'd0; tick();
    chk("win0", 64'(hex), hx(S0, S0, S5, S0, S2));

    // Freeze
    frz = 1'b1;
    pulse(64'h503);
    pulse(64'h504);
    tick();
    chk("freeze_hex", 64'(hex), hx(S0, S0, S5, S0, S2));
    chk("freeze_missed", 64'(missed), 64'd15);
    chk("pre_rst_active", 64'({synced, seq_err, trig_led}), 64'b111);

    // Asynchronous reset, away from any clock edge
    rst_n = 1'b0;
    #2;
    chk("arst_synced", 64'({synced, tmo}), 64'd0);
    chk("arst_missed", 64'(missed), 64'd0);
    chk("arst_leds", 64'({trig_led, err_led, seq_err}), 64'd0);
    chk("arst_hex", 64'(hex), hx(S0, S0, S0, S0, S0));
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pulse_id_monitor.md
Name: pulse_id_monitor

Overview:
Parametrised monitor between the embedded receiver and the board I/O. It latches the pulse-ID on every trigger and checks that consecutive IDs increment by one, counting missed pulses. It detects trigger loss by timeout and drives a selectable window of the ID onto N seven-segment digits, with retriggerable LED pulse stretchers. It replaces the fixed five-digit display and the standalone error stretcher used in the receiver demo top level.

Parameters:
ID_WIDTH, 64, pulse-ID width in bits; multiple of 4
DIGITS, 5, number of seven-segment digits driven
WIN_WIDTH, 4, width of window_i; covers ID_WIDTH/4 nibble positions
EXTEND_CYCLES, 5000000, LED stretch length in clocks (100 ms at 50 MHz)
TIMEOUT_CYCLES, 50000000, clocks without a trigger before declaring loss (1 s at 50 MHz)
CNT_WIDTH, 16, width of the missed-pulse counter

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous reset, active low
trigger_i  in  1  single-cycle trigger strobe from the receiver
pulse_id_i  in  ID_WIDTH  pulse-ID, valid in the trigger_i cycle
error_i  in  1  receiver error strobe
window_i  in  WIN_WIDTH  nibble index shown on digit 0
freeze_i  in  1  hold the displayed ID while high
clear_i  in  1  synchronous clear of counters and status
hex_o  out  7*DIGITS  segments, active low; digit k at [7k+6:7k], bit0=a to bit6=g
missed_o  out  CNT_WIDTH  missed-pulse count, saturating
synced_o  out  1  high in TRACK state
timeout_o  out  1  high in LOST state
trig_led_o  out  1  stretched trigger_i
err_led_o  out  1  stretched error_i
seq_err_o  out  1  stretched sequence-error event

Behaviour:
- Reset values (async, reset_ni=0): state IDLE, last_id=0, disp_id=0, missed_o=0, all stretchers 0, timeout counter 0. Each hex_o digit shows "0" (7'b1000000), or blank if out of range. synced_o=0, timeout_o=0.
- FSM states:
  - IDLE: on the first trigger, last_id<=pulse_id_i and go to TRACK. No missed accounting.
  - TRACK: on each trigger compute d = pulse_id_i - last_id mod 2^ID_WIDTH.
    - d==1: OK.
    - d==0 or d>=2^(ID_WIDTH-1): duplicate or backward; fire seq-error event, missed unchanged.
    - Otherwise: missed_o += d-1, saturating at 2^CNT_WIDTH-1, and fire seq-error event.
    - last_id<=pulse_id_i in all cases.
  - Timeout counter resets on every trigger. When it reaches TIMEOUT_CYCLES in TRACK, go to LOST.
  - LOST: next trigger resyncs (last_id<=pulse_id_i, no accounting) and returns to TRACK.
- error_i never changes state; it only drives err_led_o.
- Stretchers are retriggerable. Output goes high the cycle after the input is high and stays high until EXTEND_CYCLES cycles after the last high input.
- Display path:
  - disp_id<=pulse_id_i on trigger when freeze_i=0, one cycle latency.
  - Digit k shows nibble (window_i+k) of disp_id as hex 0-F. Indices >= ID_WIDTH/4 are blank (7'h7F).
  - hex_o is registered: trigger at cycle N -> disp_id at N+1 -> hex_o at N+2. A window_i change appears on hex_o one cycle later.
- clear_i: missed_o<=0, stretchers<=0, state<=IDLE, timeout counter<=0. disp_id is kept. A trigger in the same cycle is ignored (clear wins).
- Trigger in the same cycle the timeout would expire: trigger wins, state stays TRACK.
- missed_o wraps never; it holds at max until clear or reset.
- Reset asserted mid-operation returns everything to reset values immediately.

Test Plan:
- Reset, then triggers with IDs 0x10, 0x11, 0x12 -> synced_o=1 after the first, missed_o=0, seq_err_o stays 0; hex_o digits 0..1 show "2","1" two cycles after the last trigger.
- TRACK at last_id=0x100, trigger ID 0x105 -> missed_o=4 and seq_err_o high for EXTEND_CYCLES. Then trigger 0x103 (backward) -> missed_o still 4, seq_err_o retriggered.
- CNT_WIDTH=4, jump of 20 IDs -> missed_o=15 (saturated). Then clear_i with a simultaneous trigger -> missed_o=0, state IDLE, trigger ignored.
- TIMEOUT_CYCLES=100, no triggers for 100 cycles -> timeout_o=1, synced_o=0. Next trigger ID 0x500 -> TRACK, missed_o unchanged.
- window_i=15, ID_WIDTH=64, DIGITS=5 -> digit 0 shows nibble 15; digits 1-4 blank (7'h7F). freeze_i=1 during triggers -> hex_o constant.
- Assert reset_ni low mid-stretch and mid-TRACK -> all outputs go to reset values in the same cycle, asynchronously.
